// File: rtl/mxv1_prev_result_reader.sv
// Reader side of the single-entry previous-mXv1-result store.
// On start (IDLE only) the stored wide vector is snapshotted. The snapshot is then streamed
// one element per valid/ready handshake, element 0 first. A one-cycle done pulse follows the
// last accepted element. Writes to vector_in after capture never reach the current stream.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start          - read request, honoured only in IDLE
//   vector_in      - stored result, element k at [k*E +: E]
//   busy           - high in STREAM and DONE
//   element_out    - current element (0 when not valid)
//   element_index  - index of element_out (0 when not valid)
//   element_valid  - element_out/element_index valid
//   element_ready  - consumer accepts when high with element_valid
//   last           - valid element is index N-1
//   done           - one-cycle pulse after the last element is accepted
module mxv1_prev_result_reader #(
  parameter int unsigned number_of_equations_per_cluster = 9,
  parameter int unsigned element_width                   = 32,
  parameter int unsigned index_width                     = 4
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     start,
  input  logic [number_of_equations_per_cluster*element_width-1:0] vector_in,
  output logic                                                     busy,
  output logic [element_width-1:0]                                 element_out,
  output logic [index_width-1:0]                                   element_index,
  output logic                                                     element_valid,
  input  logic                                                     element_ready,
  output logic                                                     last,
  output logic                                                     done
);

  localparam int unsigned N  = number_of_equations_per_cluster;
  localparam int unsigned E  = element_width;
  localparam int unsigned IW = index_width;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e          state_q, state_d;
  logic [N*E-1:0]  snap_q, snap_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [E-1:0]    elem_sel;
  logic            is_last;

  // Element mux driven only by registers, so element_out is stable for the whole cycle.
  always_comb begin
    elem_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) elem_sel = snap_q[k*E +: E];
    end
  end

  assign is_last = (idx_q == LastIdx);

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    idx_d         = idx_q;
    busy          = 1'b0;
    element_out   = '0;
    element_index = '0;
    element_valid = 1'b0;
    last          = 1'b0;
    done          = 1'b0;
    case (state_q)
      StIdle: begin
        // Snapshot is written only here, which isolates the stream from later stores.
        if (start) begin
          state_d = StStream;
          snap_d  = vector_in;
          idx_d   = '0;
        end
      end
      StStream: begin
        busy          = 1'b1;
        element_valid = 1'b1;
        element_out   = elem_sel;
        element_index = idx_q;
        last          = is_last;
        if (element_ready) begin
          if (is_last) begin
            state_d = StDone;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_mxv1_prev_result_reader.sv
module tb_mxv1_prev_result_reader;

  localparam int N = 9;
  localparam int E = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N*E-1:0] vector_in;
  logic           busy;
  logic [E-1:0]   element_out;
  logic [3:0]     element_index;
  logic           element_valid;
  logic           element_ready;
  logic           last;
  logic           done;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard entry: {index, data}
  logic [35:0] sb_q[$];

  always #5 clk = ~clk;

  mxv1_prev_result_reader #(
    .number_of_equations_per_cluster(N),
    .element_width(E),
    .index_width(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .vector_in(vector_in),
    .busy(busy),
    .element_out(element_out),
    .element_index(element_index),
    .element_valid(element_valid),
    .element_ready(element_ready),
    .last(last),
    .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vector(input logic [31:0] base);
    for (int k = 0; k < N; k++) vector_in[k*E +: E] = base + 32'(k);
  endtask

  task automatic push_expected(input logic [31:0] base);
    for (int k = 0; k < N; k++) sb_q.push_back({4'(k), base + 32'(k)});
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; element_ready = 1'b0; vector_in = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      @(negedge clk);
      vectors++;
      if ({busy, element_valid, last, done, element_index, element_out} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: busy/valid/last/done=%b%b%b%b idx=%0d data=%h, required all 0",
                 i, busy, element_valid, last, done, element_index, element_out);
      end
    end
  endtask

  // Full-rate stream: start in the current cycle, elements in t+1..t+9, done at t+10.
  // Returns positioned in the done cycle, after its sample point.
  task automatic run_full_stream(input string name, input logic [31:0] base);
    logic [35:0] exp;
    logic [3:0]  exp_flags;
    load_vector(base);
    element_ready = 1'b1;
    start = 1'b1;
    push_expected(base);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_flags = {1'b1, i <= 9, i == 9, i == 10};
      vectors++;
      if ({busy, element_valid, last, done} !== exp_flags) begin
        miscompares++;
        $display("FAIL %s flags cyc%0d: busy/valid/last/done=%b%b%b%b, required %b",
                 name, i, busy, element_valid, last, done, exp_flags);
      end
      exp = '0;
      if (i <= 9) begin
        if (sb_q.size() != 0) exp = sb_q.pop_front();
      end
      vectors++;
      if ({element_index, element_out} !== exp) begin
        miscompares++;
        $display("FAIL %s data cyc%0d: idx=%0d data=%h, required idx=%0d data=%h",
                 name, i, element_index, element_out, exp[35:32], exp[31:0]);
      end
      if (i < 10) tick();
    end
  endtask

  task automatic test_full_rate();
    tick();
    run_full_stream("full_rate", 32'h1000_0000);
  endtask

  task automatic test_backpressure();
    int last_acc = -100;
    bit seen_done = 0;
    logic [35:0] exp;
    tick();
    load_vector(32'h1000_0000);
    push_expected(32'h1000_0000);
    element_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 40 && !seen_done; i++) begin
      element_ready = i[0];
      @(negedge clk);
      if (element_valid) begin
        exp = (sb_q.size() != 0) ? sb_q[0] : 36'hF_FFFF_FFFF;
        vectors++;
        if ({element_index, element_out, last} !== {exp, exp[35:32] == 4'd8}) begin
          miscompares++;
          $display("FAIL backpressure elem cyc%0d: idx=%0d data=%h last=%b, required idx=%0d data=%h",
                   i, element_index, element_out, last, exp[35:32], exp[31:0]);
        end
        if (element_ready && sb_q.size() != 0) begin
          void'(sb_q.pop_front());
          if (exp[35:32] == 4'd8) last_acc = i;
        end
      end else if (done) begin
        seen_done = 1;
        vectors++;
        if (i != last_acc + 1 || sb_q.size() != 0) begin
          miscompares++;
          $display("FAIL backpressure done: at cyc%0d with %0d pending, required cyc%0d with 0",
                   i, sb_q.size(), last_acc + 1);
        end
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL backpressure valid_drop cyc%0d: valid=0 busy=%b, required valid=1 (%0d pending)",
                 i, busy, sb_q.size());
        seen_done = 1;
      end
      if (!seen_done) tick();
    end
    if (!seen_done) begin
      vectors++;
      miscompares++;
      $display("FAIL backpressure timeout: done=0, required done within 40 cycles");
    end
    sb_q.delete();
    element_ready = 1'b1;
  endtask

  task automatic test_isolation();
    logic [35:0] exp;
    tick();
    load_vector(32'h2000_0000);
    push_expected(32'h2000_0000);
    element_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    vector_in = {N{32'hDEAD_BEEF}};
    for (int i = 1; i <= 12; i++) begin
      start = (i == 3 || i == 10);
      @(negedge clk);
      exp = '0;
      if (i <= 9 && sb_q.size() != 0) exp = sb_q.pop_front();
      vectors++;
      if ({element_index, element_out, element_valid, done, busy} !==
          {exp, i <= 9, i == 10, i <= 10}) begin
        miscompares++;
        $display("FAIL isolation cyc%0d: idx=%0d data=%h v/d/b=%b%b%b, required idx=%0d data=%h v/d/b=%b%b%b",
                 i, element_index, element_out, element_valid, done, busy, exp[35:32], exp[31:0],
                 i <= 9, i == 10, i <= 10);
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp;
    load_vector(32'h3000_0000);
    push_expected(32'h3000_0000);
    element_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      vectors++;
      if ({element_valid, element_index, element_out} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL reset_mid pre cyc%0d: v=%b idx=%0d data=%h, required v=1 idx=%0d data=%h",
                 i, element_valid, element_index, element_out, exp[35:32], exp[31:0]);
      end
      tick();
    end
    sb_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, element_valid, last, done, element_index, element_out} !== '0) begin
        miscompares++;
        $display("FAIL reset_mid post cyc%0d: busy/valid/last/done=%b%b%b%b idx=%0d data=%h, required all 0",
                 i, busy, element_valid, last, done, element_index, element_out);
      end
      if (i < 2) tick();
    end
    tick();
    run_full_stream("reset_followup", 32'h4000_0000);
  endtask

  task automatic test_back_to_back();
    tick();
    run_full_stream("b2b_first", 32'h5000_0000);
    tick();
    run_full_stream("b2b_second", 32'h6000_0000);
    tick();
    @(negedge clk);
    vectors++;
    if ({busy, element_valid, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_idle: busy/valid/done=%b%b%b, required 000", busy, element_valid, done);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mxv1_prev_result_reader.md
Name: mxv1_prev_result_reader

Overview:
- Reader side of the single-entry previous-mXv1-result store.
- On `start`, snapshots the stored wide result vector, then streams it out one element per handshake, element 0 first.
- Downstream consumers (residual/convergence update, host readback) get the result as a serial valid/ready stream.
- The snapshot decouples the stream from writes to the store that land mid-stream.

Parameters:
- number_of_equations_per_cluster, 9, elements per stored result vector (N ≥ 2).
- element_width, 32, bits per element (E).
- index_width, 4, width of element index; must satisfy 2^index_width ≥ N.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to read the current stored vector; honoured only in IDLE.
- vector_in  in  E*N  stored previous result; element k occupies bits [k*E +: E].
- busy  out  1  high in STREAM and DONE states.
- element_out  out  E  current element from snapshot.
- element_index  out  index_width  index of element_out.
- element_valid  out  1  element_out/element_index are valid.
- element_ready  in  1  consumer accepts element when high with element_valid.
- last  out  1  high with element_valid when element_index == N-1.
- done  out  1  one-cycle pulse after last element accepted.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; snapshot cleared to 0; index=0.
  - Outputs: busy=0, element_valid=0, last=0, done=0, element_out=0, element_index=0.
  - Reset overrides all other inputs, including mid-stream; a partially sent stream is abandoned with no done pulse.
- States IDLE, STREAM, DONE.
- IDLE:
  - On posedge with start=1: snapshot <= vector_in, index <= 0, go STREAM.
  - Cycle t start → element_valid=1 in cycle t+1 with element 0.
- STREAM:
  - element_valid=1.
  - element_out = snapshot[index*E +: E], a mux from the registered snapshot and index, so it is glitch-free per cycle.
  - Handshake fires on a posedge with element_valid & element_ready:
    - If index == N-1: go DONE and index <= 0.
    - Else: index <= index+1.
  - element_valid & !element_ready: element_out, element_index and last are held unchanged. Valid never drops before acceptance.
- DONE:
  - done=1 for exactly one cycle; element_valid=0; busy=1.
  - Next posedge returns to IDLE unconditionally.
- start is ignored in STREAM and DONE; it is not queued.
  - start asserted in the DONE cycle is also ignored; a new read needs start in IDLE.
- Changes on vector_in after capture never affect the current stream. The snapshot is written only on the IDLE→STREAM transition.
- element_ready while element_valid=0 is ignored.
- Throughput: with element_ready held high, one element per cycle.
  - Start at t: elements in t+1..t+N, done at t+N+1, IDLE at t+N+2.
- element_out and element_index read 0 whenever element_valid=0.
- Arithmetic: index increment is unsigned modulo 2^index_width. It never wraps in practice because the terminal compare is against N-1.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst 3 cycles, then idle 5 cycles with start=0.
  - Required: all outputs 0, busy=0 throughout.
- Full-rate read:
  - Stimulus: vector_in elements k = 32'h1000_0000+k (N=9), start pulse at cycle 10, element_ready=1.
  - Required: valid at cycles 11–19 with element_out 1000_0000..1000_0008 and index 0..8; last only at 19; done only at 20; busy 11–20.
- Backpressure:
  - Stimulus: same vector, element_ready low on every other cycle.
  - Required: each element held stable while ready=0; all 9 accepted exactly once, in order; done one cycle after element 8 is accepted.
- Snapshot isolation and start-ignore:
  - Stimulus: after start, drive vector_in to all 32'hDEADBEEF and re-pulse start during STREAM and in DONE.
  - Required: streamed data is the original vector; no second stream begins.
- Reset mid-stream:
  - Stimulus: assert rst after element 4 is accepted.
  - Required: next cycle all outputs 0, no done pulse.
  - Follow-up: a new start reads vector_in fresh from element 0.
- Back-to-back reads:
  - Stimulus: start in the first IDLE cycle after done.
  - Required: second stream begins the following cycle with element 0 of the newly captured vector.
